bft_tx_scheduler: RTL and testbench

BFT_TX_SCHEDULER -- requirements
Module: bft_tx_scheduler

---
 rtl/bft_tx_scheduler.sv | 164 ++++++++++++++++
 tb/tb_bft_tx_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bft_tx_scheduler.sv
// Round-robin scheduler merging NUM_REQ user streams onto one registered BFT packet output.
// Optional per-requester credit gating is enabled by defining TX_SCHED_CREDIT_EN.
module bft_tx_scheduler #(
    parameter int unsigned NUM_REQ               = 4,
    parameter int unsigned PAYLOAD_BITS          = 32,
    parameter int unsigned PACKET_BITS           = 49,
    parameter int unsigned FREESPACE_UPDATE_SIZE = 64,
    localparam int unsigned IdxW                 = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                i_req_valid,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]                o_req_ready,
    input  logic [NUM_REQ*9-1:0]              i_req_dest,
    input  logic                              i_credit_valid,
    input  logic [IdxW-1:0]                   i_credit_idx,
    output logic [PACKET_BITS-1:0]            o_bft_data,
    input  logic                              i_bft_ready
);

    typedef enum logic {StIdle, StSend} state_e;

    state_e                   r_state;
    state_e                   w_state_next;
    logic [PACKET_BITS-1:0]   r_pkt;
    logic [IdxW-1:0]          r_last;
    logic [6:0]               r_seq [NUM_REQ];
    logic [NUM_REQ-1:0]       w_eligible;
    logic                     w_found;
    logic [IdxW-1:0]          w_sel;
    logic                     w_do_grant;
    logic [PAYLOAD_BITS-1:0]  w_payload;
    logic [8:0]               w_dest;
    logic [6:0]               w_seq;

`ifdef TX_SCHED_CREDIT_EN
    logic [7:0] r_credit      [NUM_REQ];
    logic [7:0] w_credit_next [NUM_REQ];

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            w_eligible[k] = i_req_valid[k] && (r_credit[k] != 8'd0);
        end
    end

    // Grant never underflows: a granted requester always holds at least one credit.
    always_comb begin
        logic [9:0] v_sum;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_sum = {2'b00, r_credit[k]};
            if (i_credit_valid && (i_credit_idx == IdxW'(k))) begin
                v_sum = v_sum + 10'(FREESPACE_UPDATE_SIZE);
            end
            if (o_req_ready[k]) begin
                v_sum = v_sum - 10'd1;
            end
            w_credit_next[k] = (v_sum > 10'd255) ? 8'hFF : v_sum[7:0];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_REQ; k++) begin
            if (reset) begin
                r_credit[k] <= 8'(FREESPACE_UPDATE_SIZE);
            end else begin
                r_credit[k] <= w_credit_next[k];
            end
        end
    end
`else
    logic w_unused_credit;
    assign w_unused_credit = ^{i_credit_valid, i_credit_idx};
    assign w_eligible      = i_req_valid;
`endif

    // Search starts one past the last winner and wraps modulo NUM_REQ.
    always_comb begin
        logic [IdxW:0] v_idx;
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            v_idx = {1'b0, r_last} + (IdxW + 1)'(i);
            if (v_idx >= (IdxW + 1)'(NUM_REQ)) begin
                v_idx = v_idx - (IdxW + 1)'(NUM_REQ);
            end
            if (!w_found && w_eligible[v_idx[IdxW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = v_idx[IdxW-1:0];
            end
        end
    end

    assign w_do_grant = !reset && w_found && ((r_state == StIdle) || i_bft_ready);

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            o_req_ready[k] = w_do_grant && (w_sel == IdxW'(k));
        end
    end

    always_comb begin
        w_payload = '0;
        w_dest    = '0;
        w_seq     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_sel == IdxW'(k)) begin
                w_payload = i_req_data[k*PAYLOAD_BITS +: PAYLOAD_BITS];
                w_dest    = i_req_dest[k*9 +: 9];
                w_seq     = r_seq[k];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_do_grant) begin
                    w_state_next = StSend;
                end
            end
            StSend: begin
                if (i_bft_ready) begin
                    w_state_next = w_do_grant ? StSend : StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pkt  <= '0;
            r_last <= IdxW'(NUM_REQ - 1);
        end else if (w_do_grant) begin
            r_pkt  <= PACKET_BITS'({1'b1, w_dest, w_seq, w_payload});
            r_last <= w_sel;
        end else if ((r_state == StSend) && i_bft_ready) begin
            r_pkt  <= '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_REQ; k++) begin
            if (reset) begin
                r_seq[k] <= 7'd0;
            end else if (o_req_ready[k]) begin
                r_seq[k] <= r_seq[k] + 7'd1;
            end
        end
    end

    assign o_bft_data = r_pkt;

endmodule

// File: tb/tb_bft_tx_scheduler.sv
// Scoreboard bench for bft_tx_scheduler: stimulus pushes expected packets, a monitor pops them
// as the BFT side accepts each one.
module tb_bft_tx_scheduler;

`ifdef TX_SCHED_CREDIT_EN
    localparam logic [3:0] ExpBlocked = 4'b0000;
`else
    localparam logic [3:0] ExpBlocked = 4'b0010;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  i_req_valid;
    logic [127:0] i_req_data;
    logic [3:0]  o_req_ready;
    logic [35:0] i_req_dest;
    logic        i_credit_valid;
    logic [1:0]  i_credit_idx;
    logic [48:0] o_bft_data;
    logic        i_bft_ready;

    logic [31:0] tb_data [4];
    logic [8:0]  tb_dest [4];
    logic [6:0]  exp_seq [4];
    logic [48:0] exp_q [$];
    logic [48:0] last_pkt;
    logic [48:0] hold_pkt;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    assign i_req_data = {tb_data[3], tb_data[2], tb_data[1], tb_data[0]};
    assign i_req_dest = {tb_dest[3], tb_dest[2], tb_dest[1], tb_dest[0]};

    bft_tx_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .i_req_valid    (i_req_valid),
        .i_req_data     (i_req_data),
        .o_req_ready    (o_req_ready),
        .i_req_dest     (i_req_dest),
        .i_credit_valid (i_credit_valid),
        .i_credit_idx   (i_credit_idx),
        .o_bft_data     (o_bft_data),
        .i_bft_ready    (i_bft_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [48:0] exp_pkt;
        forever begin
            @(negedge clk);
            if (!reset && i_bft_ready && o_bft_data[48]) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pkt: got %h, expected no packet", o_bft_data);
                end else begin
                    exp_pkt = exp_q.pop_front();
                    chk("delivered_pkt", 64'(o_bft_data), 64'(exp_pkt));
                end
            end
        end
    endtask

    // One cycle: drive inputs, check the grant strobe, push the packet the grant should produce.
    task automatic cyc(input logic [3:0] v, input logic rdy, input logic [3:0] exp_rdy,
                       input string name);
        i_req_valid = v;
        i_bft_ready = rdy;
        @(negedge clk);
        chk(name, 64'(o_req_ready), 64'(exp_rdy));
        for (int k = 0; k < 4; k++) begin
            if (exp_rdy[k]) begin
                last_pkt = {1'b1, tb_dest[k], exp_seq[k], tb_data[k]};
                exp_q.push_back(last_pkt);
                exp_seq[k] = exp_seq[k] + 7'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n_pending);
        reset          = 1'b1;
        i_req_valid    = 4'hF;
        i_bft_ready    = 1'b0;
        i_credit_valid = 1'b0;
        i_credit_idx   = 2'd0;
        @(negedge clk);
        chk("ready_in_reset", 64'(o_req_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("reset_pkt_zero", 64'(o_bft_data), 64'd0);
        chk("undelivered_count", 64'(exp_q.size()), 64'(n_pending));
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_seq[k] = 7'd0;
        reset       = 1'b0;
        i_req_valid = 4'h0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            tb_data[k] = 32'd0;
            tb_dest[k] = 9'd0;
            exp_seq[k] = 7'd0;
        end
        reset          = 1'b1;
        i_req_valid    = 4'h0;
        i_bft_ready    = 1'b0;
        i_credit_valid = 1'b0;
        i_credit_idx   = 2'd0;
        fork
            monitor();
        join_none
        @(posedge clk);
        #1;
        do_reset(0);

        // Single packet with latency 1, then back to idle.
        tb_data[0] = 32'hDEADBEEF;
        tb_dest[0] = {5'd3, 4'd2};
        cyc(4'b0001, 1'b1, 4'b0001, "first_grant");
        chk("first_pkt", 64'(o_bft_data), 64'({1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF}));
        cyc(4'b0000, 1'b1, 4'b0000, "first_drain");
        chk("idle_pkt_zero", 64'(o_bft_data), 64'd0);

        // Round robin, all requesters valid, one grant per cycle.
        do_reset(0);
        for (int k = 0; k < 4; k++) begin
            tb_data[k] = 32'h1111_0000 * (k + 1);
            tb_dest[k] = 9'(k * 37 + 5);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(4'hF, 1'b1, 4'(1 << (i % 4)), "rr_order");
        end
        cyc(4'h0, 1'b1, 4'h0, "rr_drain");

        // Backpressure: output holds, no grants, then resumes with the next requester.
        do_reset(0);
        cyc(4'b0001, 1'b1, 4'b0001, "stall_grant");
        hold_pkt = last_pkt;
        for (int i = 0; i < 5; i++) begin
            cyc(4'b0011, 1'b0, 4'b0000, "stall_no_ready");
            chk("stall_hold", 64'(o_bft_data), 64'(hold_pkt));
        end
        cyc(4'b0011, 1'b1, 4'b0010, "stall_release");
        cyc(4'b0000, 1'b1, 4'b0000, "stall_drain");

        // Credit exhaustion and return on requester 1.
        do_reset(0);
        for (int i = 0; i < 64; i++) begin
            cyc(4'b0010, 1'b1, 4'b0010, "credit_use");
        end
        cyc(4'b0010, 1'b1, ExpBlocked, "credit_blocked");
        i_credit_valid = 1'b1;
        i_credit_idx   = 2'd1;
        cyc(4'b0010, 1'b1, ExpBlocked, "credit_return_cycle");
        i_credit_valid = 1'b0;
        cyc(4'b0010, 1'b1, 4'b0010, "credit_regrant");
        cyc(4'b0000, 1'b1, 4'b0000, "credit_drain");

        // Sequence wrap on requester 2, then reset while a packet is held.
        do_reset(0);
        tb_dest[2] = {5'd17, 4'd9};
        for (int i = 0; i < 130; i++) begin
            tb_data[2] = 32'hC000_0000 + 32'(i);
            if (i % 32 == 0) begin
                i_credit_valid = 1'b1;
                i_credit_idx   = 2'd2;
            end
            cyc(4'b0100, 1'b1, 4'b0100, "seq_stream");
            i_credit_valid = 1'b0;
            if (i == 128) chk("seq_wrapped", 64'(o_bft_data[38:32]), 64'd0);
        end
        cyc(4'b0000, 1'b0, 4'b0000, "hold_before_reset");
        do_reset(1);
        tb_data[2] = 32'h0BAD_F00D;
        cyc(4'b0100, 1'b1, 4'b0100, "post_reset_grant");
        chk("post_reset_seq", 64'(o_bft_data[38:32]), 64'd0);
        cyc(4'b0000, 1'b1, 4'b0000, "final_drain");
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
